// File: rtl/conv_pkg.sv
// Shared constants, state encoding and packed types for the 3x3 convolution window feeder.
package conv_pkg;

    localparam int PIX_W_C = 8;
    localparam int KER_W_C = 4;
    localparam int WIN_N   = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } conv_state_e;

    typedef logic [WIN_N*PIX_W_C-1:0] win_t;
    typedef logic [WIN_N*KER_W_C-1:0] ker_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One row of pixel history: asynchronous read, synchronous write at the same address,
// so a read in the write cycle returns the old contents.
module conv_line_buffer import conv_pkg::*; #(
    parameter int DEPTH = 128,
    parameter int WIDTH = PIX_W_C,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/conv_window_buffer.sv
// Raster pixel stream to registered 3x3 window plus frame-stable kernel for the MAC stage.
// Optional macro CONV_WIN_CNT_EN adds a saturating 16-bit count of emitted windows (o_win_cnt).
module conv_window_buffer import conv_pkg::*; #(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int PIX_W = PIX_W_C,
    parameter int KER_W = KER_W_C
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   i_start,
    input  logic                   i_pix_valid,
    input  logic [PIX_W-1:0]       i_pix,
    output logic                   o_pix_ready,
    input  logic                   i_stall,
    input  logic                   i_ker_load,
    input  logic [WIN_N*KER_W-1:0] i_ker_data,
    output logic [WIN_N*PIX_W-1:0] o_win,
    output logic [WIN_N*KER_W-1:0] o_ker,
    output logic                   o_valid,
    output logic                   o_busy,
`ifdef CONV_WIN_CNT_EN
    output logic [15:0]            o_win_cnt,
`endif
    output logic                   o_frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]             state_q, state_d;
    logic [CW-1:0]          col_q, col_d;
    logic [RW-1:0]          row_q, row_d;
    logic [WIN_N*PIX_W-1:0] win_q, win_d;
    logic [WIN_N*KER_W-1:0] ker_q, ker_d;
    logic                   valid_q, valid_d;
    logic [PIX_W-1:0]       lb0_rd_s, lb1_rd_s;
    logic                   accept_s, interior_s, last_pix_s;

    assign o_pix_ready = (state_q == ST_RUN) && !i_stall && !i_start;
    assign accept_s    = o_pix_ready && i_pix_valid;
    assign interior_s  = (row_q >= ROW_TWO) && (col_q >= COL_TWO);
    assign last_pix_s  = (row_q == ROW_LAST) && (col_q == COL_LAST);

    // lb0 holds row r-1, lb1 holds row r-2 at each column.
    conv_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(CW)) u_lb0 (
        .clk     (clk),
        .we_i    (accept_s),
        .addr_i  (col_q),
        .wdata_i (i_pix),
        .rdata_o (lb0_rd_s)
    );

    conv_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(CW)) u_lb1 (
        .clk     (clk),
        .we_i    (accept_s),
        .addr_i  (col_q),
        .wdata_i (lb0_rd_s),
        .rdata_o (lb1_rd_s)
    );

    // Next-state: restart, accept-and-shift, stall hold, or drop valid so each window shows once.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        win_d   = win_q;
        valid_d = valid_q;
        if (i_start) begin
            state_d = ST_RUN;
            col_d   = {CW{1'b0}};
            row_d   = {RW{1'b0}};
            win_d   = {(WIN_N*PIX_W){1'b0}};
            valid_d = 1'b0;
        end else if (accept_s) begin
            win_d   = {i_pix,    win_q[9*PIX_W-1:7*PIX_W],
                       lb0_rd_s, win_q[6*PIX_W-1:4*PIX_W],
                       lb1_rd_s, win_q[3*PIX_W-1:1*PIX_W]};
            valid_d = interior_s;
            if (col_q == COL_LAST) begin
                col_d = {CW{1'b0}};
                row_d = (row_q == ROW_LAST) ? {RW{1'b0}} : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            state_d = last_pix_s ? ST_DONE : ST_RUN;
        end else begin
            valid_d = i_stall ? valid_q : 1'b0;
            case (state_q)
                ST_RUN:  state_d = ST_RUN;
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Kernel capture is only possible between frames.
    always_comb begin
        if ((state_q == ST_IDLE) && i_ker_load) begin
            ker_d = i_ker_data;
        end else begin
            ker_d = ker_q;
        end
    end

    // Control and datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            col_q   <= {CW{1'b0}};
            row_q   <= {RW{1'b0}};
            win_q   <= {(WIN_N*PIX_W){1'b0}};
            ker_q   <= {(WIN_N*KER_W){1'b0}};
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            win_q   <= win_d;
            ker_q   <= ker_d;
            valid_q <= valid_d;
        end
    end

    assign o_win        = win_q;
    assign o_ker        = ker_q;
    assign o_valid      = valid_q;
    assign o_busy       = (state_q != ST_IDLE);
    assign o_frame_done = (state_q == ST_DONE);

`ifdef CONV_WIN_CNT_EN
    logic [15:0] win_cnt_q;

    // Counts freshly presented interior windows; stall holds do not count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            win_cnt_q <= 16'h0000;
        end else if (i_start) begin
            win_cnt_q <= 16'h0000;
        end else if (accept_s && interior_s) begin
            win_cnt_q <= sat_inc16(win_cnt_q);
        end else begin
            win_cnt_q <= win_cnt_q;
        end
    end

    assign o_win_cnt = win_cnt_q;
`endif

endmodule

// File: tb/tb_conv_window_buffer.sv
// Randomised bench for conv_window_buffer (4x4 image) against a frame-array reference model.
module tb_conv_window_buffer;

    localparam int W = 4;
    localparam int H = 4;
    localparam int NPIX = W * H;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        i_start = 1'b0;
    logic        i_pix_valid = 1'b0;
    logic [7:0]  i_pix = 8'h00;
    logic        o_pix_ready;
    logic        i_stall = 1'b0;
    logic        i_ker_load = 1'b0;
    logic [35:0] i_ker_data = 36'h0;
    logic [71:0] o_win;
    logic [35:0] o_ker;
    logic        o_valid;
    logic        o_busy;
    logic        o_frame_done;
`ifdef CONV_WIN_CNT_EN
    logic [15:0] o_win_cnt;
    int          m_cnt = 0;
`endif

    int total = 0;
    int bad = 0;

    // reference model state
    logic [7:0]  img [NPIX];
    int          m_state = 0;   // 0 idle, 1 run, 2 done
    int          n = 0;         // next pixel index within the frame
    logic        m_valid = 1'b0;
    logic [71:0] m_win = 72'h0;
    logic [35:0] m_ker = 36'h0;
    int          obs_new = 0;
    int          obs_done = 0;
    logic [71:0] first_win = 72'h0;
    logic [71:0] last_win = 72'h0;

    conv_window_buffer #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .KER_W(4)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_start      (i_start),
        .i_pix_valid  (i_pix_valid),
        .i_pix        (i_pix),
        .o_pix_ready  (o_pix_ready),
        .i_stall      (i_stall),
        .i_ker_load   (i_ker_load),
        .i_ker_data   (i_ker_data),
        .o_win        (o_win),
        .o_ker        (o_ker),
        .o_valid      (o_valid),
        .o_busy       (o_busy),
`ifdef CONV_WIN_CNT_EN
        .o_win_cnt    (o_win_cnt),
`endif
        .o_frame_done (o_frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // 3x3 neighbourhood ending at (r,c): element k covers row r-2+k/3, column c-2+k%3.
    function automatic logic [71:0] window(input int r, input int c);
        logic [71:0] w;
        w = 72'h0;
        for (int k = 0; k < 9; k++) begin
            w[k*8 +: 8] = img[(r - 2 + k / 3) * W + (c - 2 + k % 3)];
        end
        return w;
    endfunction

    // One clock: drive inputs, check ready, clock, update model, check outputs.
    task automatic cycle(input bit st, input bit pv, input bit stl, input bit kl, input logic [35:0] kd);
        logic exp_rdy;
        logic acc;
        int   r;
        int   c;
        i_start     = st;
        i_pix_valid = pv;
        i_stall     = stl;
        i_ker_load  = kl;
        i_ker_data  = kd;
        i_pix       = (m_state == 1 && n < NPIX) ? img[n] : 8'($urandom);
        #1;
        exp_rdy = (m_state == 1) && !stl && !st;
        check("pix_ready", {71'h0, o_pix_ready}, {71'h0, exp_rdy});
        acc = exp_rdy && pv;
        @(posedge clk);
        #1;
        if (kl && m_state == 0) m_ker = kd;
        if (st) begin
            m_state = 1;
            n = 0;
            m_valid = 1'b0;
`ifdef CONV_WIN_CNT_EN
            m_cnt = 0;
`endif
        end else if (acc) begin
            r = n / W;
            c = n % W;
            m_valid = (r >= 2) && (c >= 2);
            if (m_valid) begin
                m_win = window(r, c);
`ifdef CONV_WIN_CNT_EN
                if (m_cnt < 65535) m_cnt++;
`endif
            end
            n++;
            m_state = (n == NPIX) ? 2 : 1;
        end else begin
            if (!stl) m_valid = 1'b0;
            if (m_state == 2) m_state = 0;
        end
        check("valid", {71'h0, o_valid}, {71'h0, m_valid});
        if (m_valid) check("win", o_win, m_win);
        check("ker", {36'h0, o_ker}, {36'h0, m_ker});
        check("busy", {71'h0, o_busy}, {71'h0, (m_state != 0)});
        check("frame_done", {71'h0, o_frame_done}, {71'h0, (m_state == 2)});
`ifdef CONV_WIN_CNT_EN
        check("win_cnt", {56'h0, o_win_cnt}, 72'(m_cnt));
`endif
        if (o_valid && !stl) begin
            if (obs_new == 0) first_win = o_win;
            last_win = o_win;
            obs_new++;
        end
        if (o_frame_done) obs_done++;
    endtask

    // mode 0 steady, 1 stall on first window, 2 valid bubbles, 3 random valid/stall/kernel traffic
    task automatic run_frame(input int mode, input int restart_at, input bit kl, input logic [35:0] kd);
        int  k;
        int  stall_left;
        bit  stalled_once;
        bit  pv;
        bit  stl;
        int  rs;
        rs = restart_at;
        stall_left = 0;
        stalled_once = 1'b0;
        obs_new = 0;
        obs_done = 0;
        cycle(1'b1, 1'b1, 1'b0, kl, kd);
        k = 0;
        while (m_state != 0 && k < 400) begin
            k++;
            if (rs >= 0 && n == rs && m_state == 1) begin
                rs = -1;
                obs_new = 0;
                cycle(1'b1, 1'b1, 1'b0, 1'b1, 36'hABCDEF012);
                obs_new = 0;
            end else begin
                case (mode)
                    1:       begin pv = 1'b1; stl = (stall_left > 0); end
                    2:       begin pv = k[0]; stl = 1'b0; end
                    3:       begin pv = 1'($urandom_range(0, 1)); stl = ($urandom_range(0, 3) == 0); end
                    default: begin pv = 1'b1; stl = 1'b0; end
                endcase
                cycle(1'b0, pv, stl, (mode == 3) ? 1'($urandom_range(0, 1)) : 1'b1, 36'hFFFFFFFFF);
                if (stl) stall_left--;
                else if (mode == 1 && m_valid && !stalled_once) begin
                    stall_left = 3;
                    stalled_once = 1'b1;
                end
            end
        end
        check("frame_timeout", {71'h0, (k < 400)}, 72'h1);
        check("window_count", 72'(obs_new), 72'd4);
        check("done_pulses", 72'(obs_done), 72'd1);
`ifdef CONV_WIN_CNT_EN
        check("win_cnt_end", {56'h0, o_win_cnt}, 72'd4);
`endif
    endtask

    task automatic fill_raster();
        for (int i = 0; i < NPIX; i++) img[i] = 8'(((i / W) << 4) | (i % W));
    endtask

    initial begin
        fill_raster();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {71'h0, o_valid}, 72'h0);
        check("rst_win", o_win, 72'h0);
        check("rst_ker", {36'h0, o_ker}, 72'h0);
        check("rst_busy", {71'h0, o_busy}, 72'h0);
        check("rst_done", {71'h0, o_frame_done}, 72'h0);
        check("rst_ready", {71'h0, o_pix_ready}, 72'h0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // basic frame, kernel loaded together with start, overwrite attempts during RUN
        run_frame(0, -1, 1'b1, 36'h987654321);
        check("first_win", first_win, 72'h222120121110020100);
        check("last_win", last_win, 72'h333231232221131211);
        check("ker_const", {36'h0, o_ker}, {36'h0, 36'h987654321});

        run_frame(1, -1, 1'b0, 36'h0);
        run_frame(2, -1, 1'b0, 36'h0);
        check("bubble_first", first_win, 72'h222120121110020100);
        check("bubble_last", last_win, 72'h333231232221131211);

        // restart after pixel 0x21 (index 9) has been accepted
        run_frame(0, 10, 1'b0, 36'h0);

        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom);
            run_frame(3, -1, 1'b1, 36'($urandom) ^ {4'($urandom), 32'h0});
        end

        // asynchronous reset mid-frame
        fill_raster();
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 36'h123456789);
        for (int i = 0; i < 11; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 36'h0);
        rstn = 1'b0;
        i_start = 1'b0;
        i_stall = 1'b0;
        #1;
        check("arst_valid", {71'h0, o_valid}, 72'h0);
        check("arst_win", o_win, 72'h0);
        check("arst_ker", {36'h0, o_ker}, 72'h0);
        check("arst_busy", {71'h0, o_busy}, 72'h0);
        check("arst_done", {71'h0, o_frame_done}, 72'h0);
        check("arst_ready", {71'h0, o_pix_ready}, 72'h0);
`ifdef CONV_WIN_CNT_EN
        check("arst_cnt", {56'h0, o_win_cnt}, 72'h0);
        m_cnt = 0;
`endif
        m_state = 0;
        m_valid = 1'b0;
        m_ker = 36'h0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        run_frame(0, -1, 1'b1, 36'h0F0F0F0F0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
